// File: rtl/cariomart_cmd_uart_rx.sv
// Command-link UART receiver: 8N1 bytes at 16x oversampling, framed into SYNC/STEER/THROTTLE/BUTTONS/CSUM packets.
// Optional build macro CARIOMART_RX_TIMEOUT_EN drops a stalled partial packet after TIMEOUT_TICKS idle ticks.
module cariomart_cmd_uart_rx #(
  parameter int unsigned BAUD_DIV      = 27,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_TICKS = 320
) (
  input  logic       FAB_CLK,
  input  logic       MSS_RESET_N,
  input  logic       UART_RXD,
  output logic [7:0] STEER,
  output logic [7:0] THROTTLE,
  output logic [7:0] BUTTONS,
  output logic       PKT_VALID,
  output logic       CSUM_ERR,
  output logic       FRAME_ERR,
  output logic       RX_BUSY,
  output logic [7:0] PKT_CNT,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_BREAK} byte_state_e;
  typedef enum logic [2:0] {P_SYNC, P_STEER, P_THROT, P_BTN, P_CSUM} pkt_state_e;

  localparam logic [15:0] BAUD_MAX = 16'(BAUD_DIV - 1);

  logic [1:0]  r_sync;
  logic        w_rxd;
  logic [15:0] r_baud_cnt;
  logic        w_tick;

  // NOTE: the synchroniser resets to 1 so a reset release never looks like a start bit.
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) r_sync <= 2'b11;
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    else              r_sync <= {r_sync[0], UART_RXD};
  end
  assign w_rxd = r_sync[1];

  assign w_tick = (r_baud_cnt == BAUD_MAX);
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) r_baud_cnt <= '0;
    else              r_baud_cnt <= w_tick ? 16'd0 : r_baud_cnt + 16'd1;
  end

  // ---------------- byte FSM ----------------
  byte_state_e r_bstate, w_bnext;
  logic [3:0]  r_os_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        w_mid_start, w_bit_end;
  logic        w_rx_busy, w_byte_done, w_frame_err;

  assign w_mid_start = w_tick && (r_os_cnt == 4'd7);
  assign w_bit_end   = w_tick && (r_os_cnt == 4'd15);

  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) r_bstate <= B_IDLE;
    else              r_bstate <= w_bnext;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves a latch behind.
    w_bnext = r_bstate;
    unique case (r_bstate)
      B_IDLE:  if (!w_rxd)      w_bnext = B_START;
      B_START: if (w_mid_start) w_bnext = w_rxd ? B_IDLE : B_DATA;
      B_DATA:  if (w_bit_end && (r_bit_cnt == 3'd7)) w_bnext = B_STOP;
      B_STOP:  if (w_bit_end)   w_bnext = w_rxd ? B_IDLE : B_BREAK;
      B_BREAK: if (w_rxd)       w_bnext = B_IDLE;
      default:                  w_bnext = B_IDLE;
    endcase
  end

  always_comb begin
    w_rx_busy   = 1'b0;
    w_byte_done = 1'b0;
    w_frame_err = 1'b0;
    case (r_bstate)
      B_START, B_DATA: w_rx_busy = 1'b1;
      B_STOP: begin
        w_rx_busy   = 1'b1;
        w_byte_done = w_bit_end && w_rxd;
        w_frame_err = w_bit_end && !w_rxd;
      end
      default: ;
    endcase
  end

  // Bit-phase counter restarts at each start edge; the baud divider itself keeps free-running.
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (r_bstate == B_IDLE) begin
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
    end else if (w_tick) begin
      r_os_cnt <= (r_bstate == B_START && r_os_cnt == 4'd7) ? 4'd0 : r_os_cnt + 4'd1;
      if (r_bstate == B_DATA && r_os_cnt == 4'd15) begin
        r_shift   <= {w_rxd, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
    end
  end

  // ---------------- packet FSM ----------------
  pkt_state_e r_pstate, w_pnext;
  logic [7:0] r_sh_steer, r_sh_throt, r_sh_btn, w_csum_calc;
  logic [7:0] r_steer, r_throt, r_btn, r_pkt_cnt, r_err_cnt;
  logic       r_pkt_valid, r_csum_err, r_frame_err;
  logic       w_pkt_good, w_csum_bad, w_timeout;

  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) r_pstate <= P_SYNC;
    else              r_pstate <= w_pnext;
  end

  always_comb begin
    w_pnext = r_pstate;
    if (w_frame_err || w_timeout) begin
      w_pnext = P_SYNC;
    end else if (w_byte_done) begin
      case (r_pstate)
        P_SYNC:  if (r_shift == SYNC_BYTE) w_pnext = P_STEER;
        P_STEER: w_pnext = P_THROT;
        P_THROT: w_pnext = P_BTN;
        P_BTN:   w_pnext = P_CSUM;
        default: w_pnext = P_SYNC;
      endcase
    end
  end

  always_comb begin
    w_csum_calc = r_sh_steer ^ r_sh_throt ^ r_sh_btn;
    w_pkt_good  = 1'b0;
    w_csum_bad  = 1'b0;
    if (w_byte_done && r_pstate == P_CSUM) begin
      w_pkt_good = (r_shift == w_csum_calc);
      w_csum_bad = (r_shift != w_csum_calc);
    end
  end

  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      r_sh_steer  <= '0;
      r_sh_throt  <= '0;
      r_sh_btn    <= '0;
      r_steer     <= 8'h80;
      r_throt     <= '0;
      r_btn       <= '0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
      r_pkt_valid <= 1'b0;
      r_csum_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_pkt_valid <= w_pkt_good;
      r_csum_err  <= w_csum_bad;
      r_frame_err <= w_frame_err;
      if (w_byte_done) begin
        case (r_pstate)
          P_STEER: r_sh_steer <= r_shift;
          P_THROT: r_sh_throt <= r_shift;
          P_BTN:   r_sh_btn   <= r_shift;
          default: ;
        endcase
      end
      if (w_pkt_good) begin
        r_steer   <= r_sh_steer;
        r_throt   <= r_sh_throt;
        r_btn     <= r_sh_btn;
        r_pkt_cnt <= r_pkt_cnt + 8'd1;
      end
      if ((w_csum_bad || w_frame_err) && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

`ifdef CARIOMART_RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  logic [IDLE_W-1:0] r_idle_cnt;

  assign w_timeout = (r_idle_cnt == IDLE_W'(TIMEOUT_TICKS));
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N)                              r_idle_cnt <= '0;
    else if (w_byte_done || r_pstate == P_SYNC)    r_idle_cnt <= '0;
    else if (w_tick && r_bstate == B_IDLE && !w_timeout)
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign STEER     = r_steer;
  assign THROTTLE  = r_throt;
  assign BUTTONS   = r_btn;
  assign PKT_VALID = r_pkt_valid;
  assign CSUM_ERR  = r_csum_err;
  assign FRAME_ERR = r_frame_err;
  assign RX_BUSY   = w_rx_busy;
  assign PKT_CNT   = r_pkt_cnt;
  assign ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_cariomart_cmd_uart_rx.sv
// Directed bench for cariomart_cmd_uart_rx at BAUD_DIV=4 (64 clocks per bit).
// Expected values follow the build macro CARIOMART_RX_TIMEOUT_EN when it is defined.
module tb_cariomart_cmd_uart_rx;

  localparam int BIT_CLKS = 64;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic [7:0] steer, throttle, buttons, pkt_cnt, err_cnt;
  logic       pkt_valid, csum_err, frame_err, rx_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_csum   = 0;
  int n_frame  = 0;
  int v0, c0, f0;

  always #5 clk = ~clk;

  cariomart_cmd_uart_rx #(
    .BAUD_DIV     (4),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_TICKS(320)
  ) dut (
    .FAB_CLK    (clk),
    .MSS_RESET_N(rst_n),
    .UART_RXD   (rxd),
    .STEER      (steer),
    .THROTTLE   (throttle),
    .BUTTONS    (buttons),
    .PKT_VALID  (pkt_valid),
    .CSUM_ERR   (csum_err),
    .FRAME_ERR  (frame_err),
    .RX_BUSY    (rx_busy),
    .PKT_CNT    (pkt_cnt),
    .ERR_CNT    (err_cnt)
  );

  // Count strobe-high cycles; a correct one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (pkt_valid) n_valid <= n_valid + 1;
    if (csum_err)  n_csum  <= n_csum + 1;
    if (frame_err) n_frame <= n_frame + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_bits(1);
    end
    rxd = stop_bit;
    wait_bits(1);
    rxd = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [39:0] p);
    logic [39:0] q;
    q = p;
    for (int i = 0; i < 5; i++) begin
      send_byte(q[39:32], 1'b1);
      q = q << 8;
    end
  endtask

  task automatic snap();
    v0 = n_valid;
    c0 = n_csum;
    f0 = n_frame;
  endtask

  task automatic check_fields(input string tag, input logic [7:0] s, input logic [7:0] t,
                              input logic [7:0] b);
    check({tag, " steer"},    32'(steer),    32'(s));
    check({tag, " throttle"}, 32'(throttle), 32'(t));
    check({tag, " buttons"},  32'(buttons),  32'(b));
  endtask

  task automatic check_counts(input string tag, input int dv, input int dc, input int df,
                              input logic [7:0] pc, input logic [7:0] ec);
    check({tag, " pkt_valid pulses"}, 32'(n_valid - v0), 32'(dv));
    check({tag, " csum_err pulses"},  32'(n_csum - c0),  32'(dc));
    check({tag, " frame_err pulses"}, 32'(n_frame - f0), 32'(df));
    check({tag, " pkt_cnt"},          32'(pkt_cnt),      32'(pc));
    check({tag, " err_cnt"},          32'(err_cnt),      32'(ec));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_fields("reset", 8'h80, 8'h00, 8'h00);
    check("reset pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("reset err_cnt", 32'(err_cnt), 32'd0);
    check("reset rx_busy", 32'(rx_busy), 32'd0);
    check("reset strobes", 32'({pkt_valid, csum_err, frame_err}), 32'd0);
    rst_n = 1'b1;
    wait_bits(1);

    // 1: good packet, checksum 40^C0^03 = 83
    snap();
    send_pkt(40'hA5_40_C0_03_83);
    check_fields("t1", 8'h40, 8'hC0, 8'h03);
    check_counts("t1", 1, 0, 0, 8'd1, 8'd0);

    // 2: bad checksum, outputs hold
    snap();
    send_pkt(40'hA5_40_C0_03_84);
    check_fields("t2", 8'h40, 8'hC0, 8'h03);
    check_counts("t2", 0, 1, 0, 8'd1, 8'd1);

    // 3: framing error on STEER byte, then a clean packet (11^22^33 = 00)
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h40, 1'b0);
    wait_bits(1);
    send_pkt(40'hA5_11_22_33_00);
    check_fields("t3", 8'h11, 8'h22, 8'h33);
    check_counts("t3", 1, 0, 1, 8'd2, 8'd2);

    // 4: 16-clock glitch is a false start; next packet (7F^01^80 = FE) decodes
    snap();
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    check("t4 busy during glitch", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    wait_bits(1);
    check("t4 busy after glitch", 32'(rx_busy), 32'd0);
    check_counts("t4 glitch", 0, 0, 0, 8'd2, 8'd2);
    send_pkt(40'hA5_7F_01_80_FE);
    check_fields("t4", 8'h7F, 8'h01, 8'h80);
    check_counts("t4", 1, 0, 0, 8'd3, 8'd2);

    // 5: partial packet, 400 idle ticks, then a full packet
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (400 * 4) @(negedge clk);
    send_pkt(40'hA5_11_22_33_00);
`ifdef CARIOMART_RX_TIMEOUT_EN
    check_fields("t5", 8'h11, 8'h22, 8'h33);
    check_counts("t5", 1, 0, 0, 8'd4, 8'd2);
`else
    // A5 becomes THROTTLE, 11 BUTTONS, 22 mismatches 10^A5^11 = A4
    check_fields("t5", 8'h7F, 8'h01, 8'h80);
    check_counts("t5", 0, 1, 0, 8'd3, 8'd3);
`endif

    // 6: reset during DATA of the BUTTONS byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 3; i++) begin
      rxd = 1'(i % 2);
      wait_bits(1);
    end
    check("t6 busy mid byte", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_fields("t6 reset", 8'h80, 8'h00, 8'h00);
    check("t6 reset pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("t6 reset err_cnt", 32'(err_cnt), 32'd0);
    check("t6 reset rx_busy", 32'(rx_busy), 32'd0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    wait_bits(1);
    snap();
    send_pkt(40'hA5_12_34_56_70);
    check_fields("t6", 8'h12, 8'h34, 8'h56);
    check_counts("t6", 1, 0, 0, 8'd1, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
